// File: rtl/dmem_lane_arbiter.sv
// Data-memory port arbiter for the two issue lanes: A before B, with one stall cycle per conflict.
// Optional DMEM_ARB_FWD_EN: an A store plus a B load of the same word is forwarded instead of serialised.
module dmem_lane_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqA,
    input  logic                  weA,
    input  logic [DATA_WIDTH-1:0] addrA,
    input  logic [DATA_WIDTH-1:0] wdataA,
    input  logic                  reqB,
    input  logic                  weB,
    input  logic [DATA_WIDTH-1:0] addrB,
    input  logic [DATA_WIDTH-1:0] wdataB,
    output logic                  stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rdataA,
    output logic [DATA_WIDTH-1:0] rdataB,
    output logic                  validA,
    output logic                  validB,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic {IDLE, SERVE_B} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  hold_we_q, hold_we_d;
    logic [DATA_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic                  ld_a, ld_b, fwd;

    // Port outputs are gated by reset so a mid-SERVE_B reset silences the RAM immediately.
    always_comb begin
        state_d      = state_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        fwd          = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (reqA) begin
                        mem_en    = 1'b1;
                        mem_we    = weA;
                        mem_addr  = addrA;
                        mem_wdata = wdataA;
                        ld_a      = !weA;
                    end else if (reqB) begin
                        mem_en    = 1'b1;
                        mem_we    = weB;
                        mem_addr  = addrB;
                        mem_wdata = wdataB;
                        ld_b      = !weB;
                    end
                    if (reqA && reqB) begin
`ifdef DMEM_ARB_FWD_EN
                        fwd = weA && !weB && (addrA[DATA_WIDTH-1:2] == addrB[DATA_WIDTH-1:2]);
`endif
                        if (!fwd) begin
                            stall        = 1'b1;
                            state_d      = SERVE_B;
                            hold_we_d    = weB;
                            hold_addr_d  = addrB;
                            hold_wdata_d = wdataB;
                            if (cnt_q != CNT_MAX)
                                cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                SERVE_B: begin
                    mem_en    = 1'b1;
                    mem_we    = hold_we_q;
                    mem_addr  = hold_addr_q;
                    mem_wdata = hold_wdata_q;
                    ld_b      = !hold_we_q;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Forwarded B load takes A's store data, since the RAM read would race the write.
    always_comb begin
        valid_a_d = ld_a;
        valid_b_d = ld_b | fwd;
        rdata_a_d = ld_a ? mem_rdata : rdata_a_q;
        rdata_b_d = fwd ? wdataA : (ld_b ? mem_rdata : rdata_b_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            cnt_q        <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            valid_a_q    <= 1'b0;
            valid_b_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            cnt_q        <= cnt_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            valid_a_q    <= valid_a_d;
            valid_b_q    <= valid_b_d;
        end
    end

    assign rdataA       = rdata_a_q;
    assign rdataB       = rdata_b_q;
    assign validA       = valid_a_q;
    assign validB       = valid_b_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Directed bench for dmem_lane_arbiter with a RAM model and per-lane load scoreboards.
module tb_dmem_lane_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqA, weA, reqB, weB;
    logic [DW-1:0] addrA, wdataA, addrB, wdataB;
    logic          stall, mem_en, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [DW-1:0] rdataA, rdataB;
    logic          validA, validB;
    logic [CW-1:0] conflict_cnt;

    dmem_lane_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA),
        .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rdataA(rdataA), .rdataB(rdataB), .validA(validA), .validB(validB),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on the rising edge.
    logic [DW-1:0] ram [0:63];
    always @(posedge clk) if (mem_en && mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    assign mem_rdata = ram[mem_addr[7:2]];

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [DW-1:0] refm [0:63];
    logic [CW-1:0] exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected load of that lane at its due cycle.
    always @(negedge clk) begin
        if (validA) begin
            checks++;
            assert (qa.size() != 0) else begin errors++; $error("FAIL validA_unexpected: got=1 exp=0"); end
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                checks++;
                assert (rdataA === ea.data && cyc == ea.due) else begin
                    errors++;
                    $error("FAIL rdataA: got=%h@%0d exp=%h@%0d", rdataA, cyc, ea.data, ea.due);
                end
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            checks++; errors++;
            $error("FAIL validA_missing: got=0 exp=1 (data %h due %0d)", qa[0].data, qa[0].due);
            void'(qa.pop_front());
        end
        if (validB) begin
            checks++;
            assert (qb.size() != 0) else begin errors++; $error("FAIL validB_unexpected: got=1 exp=0"); end
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                checks++;
                assert (rdataB === eb.data && cyc == eb.due) else begin
                    errors++;
                    $error("FAIL rdataB: got=%h@%0d exp=%h@%0d", rdataB, cyc, eb.data, eb.due);
                end
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            checks++; errors++;
            $error("FAIL validB_missing: got=0 exp=1 (data %h due %0d)", qb[0].data, qb[0].due);
            void'(qb.pop_front());
        end
    end

    task automatic set_idle();
        reqA = 0; weA = 0; addrA = '0; wdataA = '0;
        reqB = 0; weB = 0; addrB = '0; wdataB = '0;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic we,
                            input logic [DW-1:0] addr, input logic [DW-1:0] wd, input logic stl);
        chk({tag, "_stall"}, 32'(stall), 32'(stl));
        chk({tag, "_en"}, 32'(mem_en), 32'(en));
        chk({tag, "_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_addr"}, mem_addr, addr);
        if (we) chk({tag, "_wdata"}, mem_wdata, wd);
    endtask

    task automatic op_single(input string tag, input bit lane_b, input bit we,
                             input logic [DW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        set_idle();
        if (lane_b) begin reqB = 1; weB = we; addrB = addr; wdataB = data; end
        else begin reqA = 1; weA = we; addrA = addr; wdataA = data; end
        if (we) refm[addr[7:2]] = data;
        else begin
            e.data = refm[addr[7:2]]; e.due = cyc + 1;
            if (lane_b) qb.push_back(e); else qa.push_back(e);
        end
        #1 chk_port(tag, 1'b1, we, addr, data, 1'b0);
        @(negedge clk);
        set_idle();
    endtask

    task automatic op_dual(input string tag,
                           input bit wa, input logic [DW-1:0] aa, input logic [DW-1:0] da,
                           input bit wb, input logic [DW-1:0] ab, input logic [DW-1:0] db);
        exp_t e;
        bit   fw;
        fw = 1'b0;
`ifdef DMEM_ARB_FWD_EN
        fw = wa && !wb && (aa[DW-1:2] == ab[DW-1:2]);
`endif
        reqA = 1; weA = wa; addrA = aa; wdataA = da;
        reqB = 1; weB = wb; addrB = ab; wdataB = db;
        if (wa) refm[aa[7:2]] = da;
        else begin e.data = refm[aa[7:2]]; e.due = cyc + 1; qa.push_back(e); end
        #1 chk_port({tag, "_c0"}, 1'b1, wa, aa, da, !fw);
        if (fw) begin
            e.data = da; e.due = cyc + 1; qb.push_back(e);
            @(negedge clk);
        end else begin
            if (exp_cnt != '1) exp_cnt++;
            @(negedge clk);
            if (wb) refm[ab[7:2]] = db;
            else begin e.data = refm[ab[7:2]]; e.due = cyc + 1; qb.push_back(e); end
            #1 chk_port({tag, "_c1"}, 1'b1, wb, ab, db, 1'b0);
            @(negedge clk);
        end
        chk({tag, "_cnt"}, 32'(conflict_cnt), 32'(exp_cnt));
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) refm[i] = '0;
        exp_cnt = '0;
        set_idle();
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdataA", rdataA, '0);
        chk("rst_rdataB", rdataB, '0);
        chk("rst_validA", 32'(validA), 32'd0);
        chk("rst_validB", 32'(validB), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        rst = 1;
        @(negedge clk);
        #1 chk("idle_en", 32'(mem_en), 32'd0);
        @(negedge clk);

        // T1 and preloads
        op_single("st_10", 0, 1, 32'h10, 32'hDEADBEEF);
        op_single("t1_ldA", 0, 0, 32'h10, 32'h0);
        op_single("st_24", 1, 1, 32'h24, 32'h24242424);
        op_single("st_14", 0, 1, 32'h14, 32'h14141414);
        op_single("st_40", 1, 1, 32'h40, 32'h0BADF00D);
        op_single("ldB_24", 1, 0, 32'h24, 32'h0);
        // T2, T3/T3'
        op_dual("t2", 1, 32'h20, 32'h11111111, 0, 32'h24, 32'h0);
        op_dual("t3", 1, 32'h40, 32'hCAFEF00D, 0, 32'h40, 32'h0);
        // A load sees old data before B's store to the same word
        op_dual("ldA_stB", 0, 32'h10, 32'h0, 1, 32'h10, 32'h55AA55AA);
        op_single("ld_10", 0, 0, 32'h10, 32'h0);
        // T4 and same-word store ordering
        op_dual("t4", 1, 32'h30, 32'hA1A1A1A1, 1, 32'h34, 32'hB2B2B2B2);
        op_dual("st_st", 1, 32'h38, 32'h00000001, 1, 32'h38, 32'h00000002);
        op_single("ld_30", 1, 0, 32'h30, 32'h0);
        op_single("ld_34", 0, 0, 32'h34, 32'h0);
        op_single("ld_38", 0, 0, 32'h38, 32'h0);
        // T5: saturation
        for (int i = 0; i < (1 << CW) + 3; i++) op_dual("t5", 0, 32'h10, 32'h0, 0, 32'h14, 32'h0);
        chk("t5_sat", 32'(conflict_cnt), 32'((1 << CW) - 1));

        // T6: reset while SERVE_B is pending
        op_single("st_54", 0, 1, 32'h54, 32'h54545454);
        reqA = 1; weA = 1; addrA = 32'h50; wdataA = 32'h50505050;
        reqB = 1; weB = 0; addrB = 32'h54; wdataB = 32'h0;
        refm[20] = 32'h50505050;
        #1 chk_port("t6_c0", 1'b1, 1'b1, 32'h50, 32'h50505050, 1'b1);
        @(negedge clk);
        rst = 0;
        #1;
        chk("t6_stall", 32'(stall), 32'd0);
        chk("t6_en", 32'(mem_en), 32'd0);
        chk("t6_validB", 32'(validB), 32'd0);
        chk("t6_cnt", 32'(conflict_cnt), 32'd0);
        exp_cnt = '0;
        set_idle();
        @(negedge clk);
        rst = 1;
        #1 chk("t6_rel_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        op_single("t6_ld50", 0, 0, 32'h50, 32'h0);
        op_single("t6_ld54", 1, 0, 32'h54, 32'h0);

        repeat (3) @(negedge clk);
        chk("end_qa", 32'(qa.size()), 32'd0);
        chk("end_qb", 32'(qb.size()), 32'd0);
        chk("end_cnt", 32'(conflict_cnt), 32'(exp_cnt));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
